// File: rtl/core_cp15_fault_log.sv
// core_cp15_fault_log: multi-channel MMU fault FIFO exposed through CP15 FSR/FAR
module core_cp15_fault_log #(
  parameter int CHANNELS = 2,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               fault_valid,
  input  logic [CHANNELS-1:0]               fault_page,
  input  logic [CHANNELS-1:0][1:0]          fault_type,
  input  logic [CHANNELS-1:0][3:0]          fault_domain,
  input  logic [CHANNELS-1:0][ADDR_W-1:0]   fault_addr,
  input  logic                              transfer,
  input  logic                              load,
  input  logic                              sel_far,
  input  logic [31:0]                       write,
  output logic [31:0]                       read,
  output logic                              fault_pending,
  output logic [$clog2(DEPTH+1)-1:0]        fault_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = ADDR_W + 11;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] sh, win, cur;
  logic [AW-1:0] rp, wp;
  logic lost, any, multi, full, mcr_fsr, mcr_far, pop, enq, lost_set;
  always_comb begin
    win = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (fault_valid[i]) win = {4'(i), fault_domain[i], fault_type[i], fault_page[i], fault_addr[i]};
    any = |fault_valid;
    multi = |(fault_valid & (fault_valid - CHANNELS'(1)));
    full = fault_count == CW'(DEPTH);
    mcr_fsr = transfer && !load && !sel_far;
    mcr_far = transfer && !load && sel_far;
    pop = mcr_fsr && write[31] && fault_pending;
    enq = any && (!full || pop);
    lost_set = multi || (any && !enq);
    cur = fault_pending ? mem[rp] : sh;
    read = sel_far ? 32'(cur[ADDR_W-1:0]) : {fault_pending, lost, 18'd0, cur[RW-1:ADDR_W], 1'b1};
  end
  assign fault_pending = fault_count != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      fault_count <= '0;
      lost <= 1'b0;
      sh <= '0;
    end else begin
      if (enq) mem[wp] <= win;
      wp <= enq ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      fault_count <= (enq && !pop) ? fault_count + CW'(1) : (pop && !enq) ? fault_count - CW'(1) : fault_count;
      lost <= lost_set ? 1'b1 : (mcr_fsr && write[30]) ? 1'b0 : lost;
      if (mcr_fsr && !write[31] && !fault_pending) sh[ADDR_W+6:ADDR_W] <= write[7:1];
      if (mcr_far) sh[ADDR_W-1:0] <= write[ADDR_W-1:0];
    end
  end
endmodule

// File: tb/tb_core_cp15_fault_log.sv
// tb_core_cp15_fault_log: directed-vector bench for the CP15 fault log FIFO
module tb_core_cp15_fault_log;
  logic clk, rst, transfer, load, sel_far, fault_pending;
  logic [1:0] fault_valid, fault_page;
  logic [1:0][1:0] fault_type;
  logic [1:0][3:0] fault_domain;
  logic [1:0][31:0] fault_addr;
  logic [31:0] write, read;
  logic [2:0] fault_count;
  int vectors = 0, miss = 0;
  logic [31:0] efsr [5], efar [5];
  core_cp15_fault_log #(.CHANNELS(2), .DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .fault_valid(fault_valid), .fault_page(fault_page),
    .fault_type(fault_type), .fault_domain(fault_domain), .fault_addr(fault_addr),
    .transfer(transfer), .load(load), .sel_far(sel_far), .write(write),
    .read(read), .fault_pending(fault_pending), .fault_count(fault_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic s, input string tag, input logic [31:0] exp);
    sel_far = s; load = 1'b1; transfer = 1'b1;
    #1 chk(tag, read, exp);
    transfer = 1'b0;
  endtask
  task automatic wr(input logic s, input logic [31:0] d);
    sel_far = s; load = 1'b0; transfer = 1'b1; write = d;
    tick;
    transfer = 1'b0; load = 1'b1; write = '0;
  endtask
  task automatic flt(input int ch, input logic [1:0] t, input logic [3:0] d, input logic p, input logic [31:0] a);
    fault_valid[ch] = 1'b1; fault_type[ch] = t; fault_domain[ch] = d; fault_page[ch] = p; fault_addr[ch] = a;
  endtask
  task automatic go;
    tick;
    fault_valid = '0;
  endtask
  task automatic cnt(input string tag, input int exp);
    chk(tag, 32'(fault_count), 32'(exp));
  endtask
  initial begin
    rst = 1'b1; transfer = 1'b0; load = 1'b1; sel_far = 1'b0; write = '0;
    fault_valid = '0; fault_page = '0; fault_type = '0; fault_domain = '0; fault_addr = '0;
    tick; tick;
    rst = 1'b0;
    rd(0, "reset_fsr", 32'h0000_0001);
    rd(1, "reset_far", 32'h0);
    cnt("reset_count", 0);
    chk("reset_pending", 32'(fault_pending), 32'd0);
    flt(0, 2'b01, 4'h3, 1'b1, 32'h1000); go;
    rd(0, "single_fsr", 32'h8000_0037);
    rd(1, "single_far", 32'h1000);
    cnt("single_count", 1);
    wr(0, 32'h8000_0000);
    cnt("pop_count", 0);
    rd(0, "empty_fsr", 32'h0000_0001);
    flt(0, 2'b10, 4'h5, 1'b0, 32'h2000); flt(1, 2'b11, 4'h7, 1'b1, 32'h3000); go;
    cnt("dual_count", 1);
    rd(0, "dual_fsr", 32'hC000_0059);
    rd(1, "dual_far", 32'h2000);
    wr(0, 32'h4000_0000);
    rd(0, "lost_clear_fsr", 32'h8000_0059);
    wr(0, 32'h8000_0000);
    cnt("dual_pop_count", 0);
    for (int i = 0; i < 5; i++) begin
      fault_valid = '0;
      flt(i % 2, 2'(i), 4'(i + 1), 1'(i), 32'h100 * (i + 1));
      efsr[i] = 32'hC000_0001 | ((i % 2) << 8) | ((i + 1) << 4) | ((i % 4) << 2) | ((i % 2) << 1);
      efar[i] = 32'h100 * (i + 1);
      tick;
    end
    fault_valid = '0;
    cnt("full_count", 4);
    for (int i = 0; i < 4; i++) begin
      rd(0, $sformatf("wrap_fsr%0d", i), efsr[i]);
      rd(1, $sformatf("wrap_far%0d", i), efar[i]);
      wr(0, 32'h8000_0000);
    end
    cnt("drained_count", 0);
    rd(0, "drained_fsr", 32'h4000_0001);
    wr(0, 32'h4000_0000);
    rd(0, "drained_clr_fsr", 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      flt(0, 2'b00, 4'h0, 1'b0, 32'hA00 + i); go;
    end
    cnt("refill_count", 4);
    flt(1, 2'b10, 4'h9, 1'b0, 32'hBEEF);
    wr(0, 32'h8000_0000);
    fault_valid = '0;
    cnt("poppush_count", 4);
    rd(0, "poppush_fsr", 32'h8000_0001);
    rd(1, "poppush_far", 32'hA01);
    wr(0, 32'h8000_0000);
    wr(0, 32'h8000_0000);
    rd(1, "tail_prev_far", 32'hA03);
    wr(0, 32'h8000_0000);
    rd(0, "tail_fsr", 32'h8000_0199);
    rd(1, "tail_far", 32'hBEEF);
    wr(0, 32'h8000_0000);
    cnt("tail_pop_count", 0);
    wr(0, 32'h0000_00A6);
    rd(0, "shadow_fsr", 32'h0000_00A7);
    wr(0, 32'h8000_0000);
    rd(0, "empty_pop_fsr", 32'h0000_00A7);
    cnt("empty_pop_count", 0);
    wr(1, 32'h1234_5678);
    rd(1, "shadow_far", 32'h1234_5678);
    rd(0, "far_wr_fsr", 32'h0000_00A7);
    flt(0, 2'b01, 4'h1, 1'b1, 32'h4444); go;
    cnt("pre_rst_count", 1);
    rst = 1'b1; tick; rst = 1'b0;
    cnt("mid_rst_count", 0);
    rd(0, "mid_rst_fsr", 32'h0000_0001);
    rd(1, "mid_rst_far", 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
